// File: rtl/escape_time_marcher.sv
// escape_time_marcher
//   Per-pixel escape-time responder for the start/done pixel-job protocol.
//   Accepts one job (start_in + curr_x/curr_y/timer) and iterates the
//   fixed-point recurrence z <- z^2 + c, where c is derived from the pixel
//   coordinate. Each job returns a one-cycle pixel_done with the coordinate
//   and an 8-bit colour. After reset a single "kick" done is emitted with
//   all-zero results so that the dispatcher starts issuing jobs.
//
// Ports
//   clk_in      system clock
//   rst_in      asynchronous active-low reset
//   start_in    one-cycle job strobe, accepted only while idle
//   curr_x/y    pixel coordinate, sampled with start_in
//   timer       frame counter, low byte sampled with start_in
//   pixel_done  one-cycle result strobe
//   color_out   result colour (0 for points that never escape)
//   out_x/y     coordinate of the result
//   busy_out    high from job capture through the done cycle
//   overrun_out sticky flag: start_in seen while not idle
module escape_time_marcher #(
    parameter int WIDTH    = 1280,
    parameter int HEIGHT   = 720,
    parameter int BITS     = 32,
    parameter int FRAC     = 16,
    parameter int STEP     = 256,
    parameter int MAX_ITER = 64
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      start_in,
    input  logic [$clog2(WIDTH)-1:0]  curr_x,
    input  logic [$clog2(HEIGHT)-1:0] curr_y,
    input  logic [31:0]               timer,
    output logic                      pixel_done,
    output logic [7:0]                color_out,
    output logic [$clog2(WIDTH)-1:0]  out_x,
    output logic [$clog2(HEIGHT)-1:0] out_y,
    output logic                      busy_out,
    output logic                      overrun_out
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    localparam logic signed [BITS-1:0] X_CENTER = BITS'(WIDTH / 2);
    localparam logic signed [BITS-1:0] Y_CENTER = BITS'(HEIGHT / 2);
    localparam logic signed [BITS-1:0] C_STEP   = BITS'(STEP);
    localparam logic signed [BITS:0]   ESC_LIM  = (BITS + 1)'(4) << FRAC;
    localparam logic [7:0]             MAX_CNT  = 8'(MAX_ITER);

    typedef enum logic [2:0] {KICK, IDLE, SETUP, ITER, DONE} state_t;

    state_t state, state_next;

    logic [XW-1:0]          x_lat;
    logic [YW-1:0]          y_lat;
    logic [7:0]             t_lat;
    logic signed [BITS-1:0] c_re, c_im;
    logic signed [BITS-1:0] zr, zi;
    logic [7:0]             iter;

    logic signed [2*BITS-1:0] p_rr, p_ii, p_ri;
    logic signed [BITS-1:0]   zr2, zi2, zri;
    logic signed [BITS:0]     mag;
    logic signed [BITS-1:0]   x_s, y_s, c_re_calc, c_im_calc;
    logic                     escaped, capped, finish;
    logic                     timer_unused;

    assign timer_unused = ^timer[31:8];

    // Full-width products, arithmetic shift back to Q format, then truncate.
    assign p_rr = zr * zr;
    assign p_ii = zi * zi;
    assign p_ri = zr * zi;
    assign zr2  = BITS'(p_rr >>> FRAC);
    assign zi2  = BITS'(p_ii >>> FRAC);
    assign zri  = BITS'(p_ri >>> FRAC);

    // One extra bit so the magnitude sum cannot wrap before the compare.
    assign mag = {zr2[BITS-1], zr2} + {zi2[BITS-1], zi2};

    assign x_s       = BITS'(x_lat);
    assign y_s       = BITS'(y_lat);
    assign c_re_calc = (x_s - X_CENTER) * C_STEP;
    assign c_im_calc = (y_s - Y_CENTER) * C_STEP;

    always_comb begin
        state_next = state;
        escaped    = 1'b0;
        capped     = 1'b0;
        finish     = 1'b0;
        case (state)
            KICK:  state_next = IDLE;
            IDLE:  if (start_in) state_next = SETUP;
            SETUP: state_next = ITER;
            ITER: begin
                escaped = (mag > ESC_LIM);
                capped  = (iter == MAX_CNT);
                finish  = escaped || capped;
                if (finish) state_next = DONE;
            end
            DONE:  state_next = IDLE;
            default: state_next = KICK;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= KICK;
        else         state <= state_next;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pixel_done  <= 1'b0;
            color_out   <= '0;
            out_x       <= '0;
            out_y       <= '0;
            busy_out    <= 1'b0;
            overrun_out <= 1'b0;
            x_lat       <= '0;
            y_lat       <= '0;
            t_lat       <= '0;
            c_re        <= '0;
            c_im        <= '0;
            zr          <= '0;
            zi          <= '0;
            iter        <= '0;
        end else begin
            pixel_done <= 1'b0;
            if (start_in && state != IDLE) overrun_out <= 1'b1;
            case (state)
                KICK: begin
                    pixel_done <= 1'b1;
                    color_out  <= '0;
                    out_x      <= '0;
                    out_y      <= '0;
                end
                IDLE: begin
                    if (start_in) begin
                        x_lat    <= curr_x;
                        y_lat    <= curr_y;
                        t_lat    <= timer[7:0];
                        busy_out <= 1'b1;
                    end
                end
                SETUP: begin
                    c_re <= c_re_calc;
                    c_im <= c_im_calc;
                    zr   <= '0;
                    zi   <= '0;
                    iter <= '0;
                end
                ITER: begin
                    // Results are registered on the edge into DONE so that
                    // they are visible during the DONE cycle itself.
                    if (finish) begin
                        pixel_done <= 1'b1;
                        out_x      <= x_lat;
                        out_y      <= y_lat;
                        color_out  <= (iter == MAX_CNT) ? 8'd0 : iter + t_lat;
                    end else begin
                        zr   <= zr2 - zi2 + c_re;
                        zi   <= (zri <<< 1) + c_im;
                        iter <= iter + 8'd1;
                    end
                end
                DONE: busy_out <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_escape_time_marcher.sv
module tb_escape_time_marcher;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic [10:0] curr_x;
    logic [9:0]  curr_y;
    logic [31:0] timer;
    logic        pixel_done;
    logic [7:0]  color_out;
    logic [10:0] out_x;
    logic [9:0]  out_y;
    logic        busy_out;
    logic        overrun_out;

    int checks = 0;
    int errors = 0;

    escape_time_marcher #(
        .WIDTH(1280), .HEIGHT(720), .BITS(32), .FRAC(16), .STEP(256), .MAX_ITER(64)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .curr_x(curr_x), .curr_y(curr_y), .timer(timer),
        .pixel_done(pixel_done), .color_out(color_out),
        .out_x(out_x), .out_y(out_y),
        .busy_out(busy_out), .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [10:0] x;
        logic [9:0]  y;
        logic [31:0] t;
        logic [7:0]  color;
        int          lat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Issue one job; pa/pb are cycle offsets after the start cycle at which a
    // stray start_in (with junk inputs) is pulsed. 0 disables.
    task automatic run_job(input logic [10:0] x, input logic [9:0] y, input logic [31:0] t,
                           input logic [7:0] ec, input int el, input int pa, input int pb,
                           input string nm);
        int n;
        bit seen;
        @(posedge clk_in); #1;
        curr_x = x; curr_y = y; timer = t; start_in = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            @(posedge clk_in); #1;
            n++;
            start_in = (n == pa || n == pb);
            if (start_in) begin
                curr_x = 11'd5; curr_y = 10'd7; timer = 32'hAA;
            end
            if (n == 1) chk({nm, "_busy_setup"}, busy_out, 1);
            if (pixel_done) seen = 1'b1;
        end
        chk({nm, "_done_seen"}, seen, 1);
        chk({nm, "_latency"}, n, el);
        chk({nm, "_color"}, color_out, ec);
        chk({nm, "_out_x"}, out_x, x);
        chk({nm, "_out_y"}, out_y, y);
        chk({nm, "_busy_done"}, busy_out, 1);
        @(posedge clk_in); #1;
        start_in = 1'b0;
        chk({nm, "_done_pulse"}, pixel_done, 0);
        chk({nm, "_busy_after"}, busy_out, 0);
    endtask

    initial begin
        vecs[0] = '{x: 11'd640,  y: 10'd360, t: 32'd5,     color: 8'd0,  lat: 67};
        vecs[1] = '{x: 11'd0,    y: 10'd0,   t: 32'd10,    color: 8'd11, lat: 4};
        vecs[2] = '{x: 11'd0,    y: 10'd0,   t: 32'h1FF,   color: 8'h00, lat: 4};
        vecs[3] = '{x: 11'd1279, y: 10'd719, t: 32'd3,     color: 8'd4,  lat: 4};
        vecs[4] = '{x: 11'd640,  y: 10'd0,   t: 32'd7,     color: 8'd9,  lat: 5};
        vecs[5] = '{x: 11'd320,  y: 10'd360, t: 32'd77,    color: 8'd0,  lat: 67};

        rst_in = 1'b0; start_in = 1'b0; curr_x = '0; curr_y = '0; timer = '0;

        // Reset state and kick pulse
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_done", pixel_done, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_ovr", overrun_out, 0);
        chk("rst_color", color_out, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_y", out_y, 0);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        chk("kick_done", pixel_done, 1);
        chk("kick_out_x", out_x, 0);
        chk("kick_out_y", out_y, 0);
        chk("kick_color", color_out, 0);
        chk("kick_busy", busy_out, 0);
        @(posedge clk_in); #1;
        chk("kick_single", pixel_done, 0);

        // Table-driven jobs, back to back
        for (int i = 0; i < 6; i++)
            run_job(vecs[i].x, vecs[i].y, vecs[i].t, vecs[i].color, vecs[i].lat, 0, 0, "vec");
        chk("vec_no_ovr", overrun_out, 0);

        // start_in during the DONE cycle is rejected
        run_job(11'd0, 10'd0, 32'd10, 8'd11, 4, 4, 0, "done_start");
        chk("done_start_ovr", overrun_out, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_in); #1;
            chk("done_start_idle_busy", busy_out, 0);
            chk("done_start_idle_done", pixel_done, 0);
        end

        // Stray starts in SETUP and ITER do not disturb the job in flight
        run_job(11'd640, 10'd360, 32'd5, 8'd0, 67, 1, 10, "ovr_job");
        chk("ovr_sticky1", overrun_out, 1);
        run_job(11'd1279, 10'd719, 32'd3, 8'd4, 4, 0, 0, "after_ovr");
        chk("ovr_sticky2", overrun_out, 1);

        // Mid-job reset
        @(posedge clk_in); #1;
        curr_x = 11'd640; curr_y = 10'd360; timer = 32'd5; start_in = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        repeat (10) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        #1;
        chk("mid_rst_done", pixel_done, 0);
        chk("mid_rst_busy", busy_out, 0);
        chk("mid_rst_ovr", overrun_out, 0);
        chk("mid_rst_color", color_out, 0);
        chk("mid_rst_out_x", out_x, 0);
        chk("mid_rst_out_y", out_y, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in); #1;
            chk("mid_rst_hold_done", pixel_done, 0);
        end
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        chk("mid_rst_kick", pixel_done, 1);
        chk("mid_rst_kick_x", out_x, 0);
        @(posedge clk_in); #1;
        chk("mid_rst_kick_single", pixel_done, 0);
        run_job(11'd0, 10'd0, 32'd10, 8'd11, 4, 0, 0, "post_rst");
        chk("post_rst_ovr", overrun_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/escape_time_marcher.md
# escape_time_marcher

Per-pixel compute responder for the renderer's start/done pixel-job protocol. It accepts one pixel job (`start_in` pulse plus `curr_x`/`curr_y`/`timer`) and iterates a fixed-point escape-time recurrence z ← z² + c, where c is derived from the pixel coordinate. It returns a one-cycle `pixel_done` with `out_x`, `out_y` and an 8-bit `color_out` for the frame-buffer write port. It drops into any raymarcher slot of the renderer, so scenes can be swapped without touching the dispatcher.

## Interface
- WIDTH, 1280, frame width in pixels
- HEIGHT, 720, frame height in pixels
- BITS, 32, signed fixed-point word width
- FRAC, 16, fractional bits (Q(BITS-FRAC).FRAC)
- STEP, 256, per-pixel increment of c in Q-format (256 = 1/256)
- MAX_ITER, 64, iteration cap, 1..255

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- start_in  input  1  one-cycle job strobe
- curr_x  input  $clog2(WIDTH)  pixel column, sampled when start_in=1
- curr_y  input  $clog2(HEIGHT)  pixel row, sampled when start_in=1
- timer  input  32  frame counter, sampled when start_in=1
- pixel_done  output  1  one-cycle result strobe
- color_out  output  8  result color
- out_x  output  $clog2(WIDTH)  column of the result
- out_y  output  $clog2(HEIGHT)  row of the result
- busy_out  output  1  high from job capture until the pixel_done cycle inclusive
- overrun_out  output  1  sticky; set when start_in arrives while busy

## Operation
- States: KICK, IDLE, SETUP, ITER, DONE.
- KICK is entered on reset. It lasts one cycle: pixel_done=1 with out_x=0, out_y=0, color_out=0, then moves to IDLE. The dispatcher issues no job until it sees a done, so this kick primes it.
- IDLE, on start_in: latch x, y and timer[7:0]; set busy_out; go to SETUP.
- SETUP:
  - c_re = (x − WIDTH/2)·STEP; c_im = (y − HEIGHT/2)·STEP, both signed BITS.
  - zr = zi = 0; iter = 0; go to ITER.
- ITER, one iteration per cycle:
  - zr2 = (zr·zr)>>>FRAC, zi2 = (zi·zi)>>>FRAC, zri = (zr·zi)>>>FRAC. Products are full 2·BITS wide; the arithmetic shift result is truncated to BITS.
  - If zr2+zi2 > 4<<FRAC, where the compare uses BITS+1-bit sums: count=iter, go to DONE.
  - Else if iter == MAX_ITER: count=MAX_ITER, go to DONE.
  - Else: zr ← zr2−zi2+c_re, zi ← 2·zri+c_im, iter ← iter+1.
- DONE, one cycle:
  - pixel_done=1; out_x/out_y = latched x/y.
  - color_out = 0 if count==MAX_ITER, else (count + timer[7:0]) mod 256.
  - busy_out cleared after this cycle; go to IDLE.
- start_in in any state other than IDLE is ignored, sets overrun_out, and does not alter the job in flight.
- start_in in the same cycle as DONE is ignored and sets overrun_out; accepted jobs begin only in IDLE.
- overrun_out clears only on reset.

## Timing
- Reset values: pixel_done=0, color_out=0, out_x=0, out_y=0, busy_out=0, overrun_out=0, state=KICK.
- The first rising edge with rst_in=1 enters KICK; pixel_done=1 in that cycle.
- Asserting rst_in=0 at any time aborts the job immediately and returns to KICK after release. No partial result is emitted.
- Job latency: start_in at cycle t → SETUP at t+1 → ITER t+2..t+2+count → pixel_done at t+3+count.
  - Minimum 3 cycles (count=0 is impossible since z=0 first, so effective minimum is 4).
  - Maximum MAX_ITER+3.
- out_x, out_y and color_out change only in the DONE cycle and hold until the next DONE/KICK. They are valid whenever pixel_done=1.
- With the dispatcher's back-to-back handshake (start one cycle after done), throughput is count+4 cycles per pixel.

## Test plan
- Reset release: exactly one pixel_done pulse, 1 cycle after release, with out_x=0, out_y=0, color=0; busy_out=0.
- Job x=640, y=360 (c=0), timer=5: count=MAX_ITER → color_out=0, pixel_done exactly 67 cycles after start_in, out=(640,360).
- Job x=0, y=0 (c≈−2.5−1.406i), timer=10: escapes at count=1 → color_out=11, pixel_done 4 cycles after start_in.
- Color wrap: same job as above with timer=0x1FF → color_out=0x00 (1+0xFF mod 256).
- Overrun: start_in pulses in SETUP and again in ITER of a job at (640,360) → in-flight result unchanged, overrun_out=1 and stays 1 after later jobs.
- Mid-job reset: rst_in=0 during ITER → all outputs 0 immediately, no done for the aborted job; after release, the KICK pulse appears and the next job completes normally.
